// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the ALU and LSU result
// paths. Each source presents its result with a valid/ready handshake. The LSU
// normally wins a collision, but an ALU result that has been refused
// STARVE_MAX times in a row wins the next collision. The winning result is
// registered onto the write-back bus, so it reaches the register file one
// cycle after its grant.
//
// Parameters
//   STARVE_MAX  most consecutive cycles a valid ALU result may be refused
//               (0 means the ALU always wins a collision)
//   CNT_W       width of the saturating conflict counter
//   XLEN        data width of a result
//   RA_W        width of a register address (5 for 32 architectural regs)
//
// Ports
//   clk           clock, single domain
//   rst           synchronous reset, active-high
//   alu_valid     ALU result pending
//   alu_ready     ALU result accepted this cycle
//   alu_rd        ALU destination register
//   alu_data      ALU result
//   lsu_valid     LSU (load) result pending
//   lsu_ready     LSU result accepted this cycle
//   lsu_rd        LSU destination register
//   lsu_data      LSU result
//   wb_en         register-file write enable
//   wb_addr       register-file write address
//   wb_data       register-file write data
//   wb_src        source of the current write: 0 = ALU, 1 = LSU
//   conflict_cnt  cycles in which both sources were valid, saturating

module wb_port_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 16,
    parameter int XLEN       = 32,
    parameter int RA_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [RA_W-1:0]  alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [RA_W-1:0]  lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    output logic             wb_en,
    output logic [RA_W-1:0]  wb_addr,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_src,
    output logic [CNT_W-1:0] conflict_cnt
);

    // With STARVE_MAX = 0 the counter never leaves zero, but it still needs
    // one bit so the comparison against the limit stays well formed.
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0]   starve_cnt;
    logic            alu_starved;
    logic            alu_grant;
    logic            lsu_grant;
    logic            any_grant;
    logic [RA_W-1:0] sel_rd;
    logic [XLEN-1:0] sel_data;

    // Grant decision. The LSU wins a collision unless the ALU has reached its
    // starvation limit. Reset suppresses both grants, so a request seen in the
    // reset cycle is never acknowledged.
    always_comb begin
        alu_starved = (starve_cnt == STARVE_LIM);
        alu_grant   = !rst && alu_valid && (!lsu_valid || alu_starved);
        lsu_grant   = !rst && lsu_valid && !(alu_valid && alu_starved);
        any_grant   = alu_grant || lsu_grant;
    end

    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;

    // Select the winning destination and data for the output register.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (alu_grant) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (lsu_grant) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    // Count consecutive refusals of a valid ALU result. Serving the ALU or
    // the ALU withdrawing its request both restart the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!alu_valid || alu_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Write-back register. Writes to x0 still complete the handshake and
    // record their source, but present an all-zero, disabled write so the
    // register file never sees x0 as a target. Idle cycles also zero the bus
    // while wb_src keeps naming the last writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            wb_src  <= 1'b0;
        end else if (any_grant) begin
            wb_src <= lsu_grant;
            if (sel_rd != '0) begin
                wb_en   <= 1'b1;
                wb_addr <= sel_rd;
                wb_data <= sel_data;
            end else begin
                wb_en   <= 1'b0;
                wb_addr <= '0;
                wb_data <= '0;
            end
        end else begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end
    end

    // Count cycles in which both sources competed; stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (alu_valid && lsu_valid && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//
// Drives two arbiter instances from the same inputs: the main instance has
// STARVE_MAX = 3 and a 4-bit conflict counter, the second has STARVE_MAX = 0
// (ALU always wins a collision). Each table entry holds one cycle of inputs
// together with hand-worked ready values for both instances and the main
// instance's write-back bus one cycle later. Ready values are checked in the
// issuing cycle. The write-back expectations go into a scoreboard queue that
// a separate monitor drains after every rising edge.

module tb_wb_port_arbiter;

    localparam logic [4:0]  AR = 5'd3;
    localparam logic [31:0] AD = 32'hAAAA_0001;
    localparam logic [4:0]  LR = 5'd4;
    localparam logic [31:0] LD = 32'hBBBB_0002;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        exp_ar;
        logic        exp_lr;
        logic        exp_ar0;
        logic        exp_lr0;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_src;
        logic [3:0]  exp_cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        src;
        logic [3:0]  cnt;
    } wb_exp_t;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;

    logic        alu_ready_m;
    logic        lsu_ready_m;
    logic        wb_en_m;
    logic [4:0]  wb_addr_m;
    logic [31:0] wb_data_m;
    logic        wb_src_m;
    logic [3:0]  cnt_m;

    logic        alu_ready_s;
    logic        lsu_ready_s;
    logic        wb_en_s;
    logic [4:0]  wb_addr_s;
    logic [31:0] wb_data_s;
    logic        wb_src_s;
    logic [15:0] cnt_s;

    vec_t    vecs[$];
    wb_exp_t sb[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    wb_port_arbiter #(.STARVE_MAX(3), .CNT_W(4), .XLEN(32), .RA_W(5)) dut_main (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready_m), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready_m), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_en(wb_en_m), .wb_addr(wb_addr_m), .wb_data(wb_data_m), .wb_src(wb_src_m),
        .conflict_cnt(cnt_m)
    );

    wb_port_arbiter #(.STARVE_MAX(0), .CNT_W(16), .XLEN(32), .RA_W(5)) dut_alu_first (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready_s), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready_s), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_en(wb_en_s), .wb_addr(wb_addr_s), .wb_data(wb_data_s), .wb_src(wb_src_s),
        .conflict_cnt(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                          input logic ar, input logic lr, input logic ar0, input logic lr0,
                          input logic en, input logic [4:0] addr, input logic [31:0] data,
                          input logic src, input logic [3:0] cnt);
        vec_t v;
        v.rst = r;  v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv;  v.lrd = lrd; v.ldat = ldat;
        v.exp_ar = ar; v.exp_lr = lr; v.exp_ar0 = ar0; v.exp_lr0 = lr0;
        v.exp_en = en; v.exp_addr = addr; v.exp_data = data; v.exp_src = src; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    // Collision cycle won by the LSU (main) / ALU (always-ALU instance).
    task automatic addL(input logic [3:0] cnt);
        addVec(0, 1, AR, AD, 1, LR, LD, 0, 1, 1, 0, 1, LR, LD, 1, cnt);
    endtask

    // Collision cycle won by the ALU on both instances.
    task automatic addA(input logic [3:0] cnt);
        addVec(0, 1, AR, AD, 1, LR, LD, 1, 0, 1, 0, 1, AR, AD, 0, cnt);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        alu_valid = v.av;
        alu_rd    = v.ard;
        alu_data  = v.adat;
        lsu_valid = v.lv;
        lsu_rd    = v.lrd;
        lsu_data  = v.ldat;
    endtask

    // Monitor: one write-back expectation per cycle, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            wb_exp_t e;
            e = sb.pop_front();
            checkOutput($sformatf("v%0d wb_en", e.idx),   32'(wb_en_m),   32'(e.en));
            checkOutput($sformatf("v%0d wb_addr", e.idx), 32'(wb_addr_m), 32'(e.addr));
            checkOutput($sformatf("v%0d wb_data", e.idx), wb_data_m,      e.data);
            checkOutput($sformatf("v%0d wb_src", e.idx),  32'(wb_src_m),  32'(e.src));
            checkOutput($sformatf("v%0d conflict_cnt", e.idx), 32'(cnt_m), 32'(e.cnt));
        end
    end

    initial begin
        // Reset, two cycles
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Single ALU write
        addVec(0, 1, 5, 32'h1234, 0, 0, 0, 1, 0, 1, 0, 1, 5, 32'h1234, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // LSU write to x0, then a normal LSU write, then idle (wb_src holds 1)
        addVec(0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 7, 32'h5555, 0, 1, 0, 1, 1, 7, 32'h5555, 1, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Collision: L,L,L,A,L then one more L (starve_cnt reaches 2)
        addL(1); addL(2); addL(3); addA(4); addL(5); addL(6);
        // Reset pulse mid-collision: no grants, everything clears
        addVec(1, 1, AR, AD, 1, LR, LD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Collision restarts from a cleared starve count; counter saturates at 15
        addL(1);  addL(2);  addL(3);  addA(4);
        addL(5);  addL(6);  addL(7);  addA(8);
        addL(9);  addL(10); addL(11); addA(12);
        addL(13); addL(14); addL(15); addA(15);
        addL(15); addL(15);
        // Idle: wb_src holds the last LSU write, counter stays saturated
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 15);
        // ALU withdrawing its request restarts the starve count
        addL(15);
        addVec(0, 0, 0, 0, 1, LR, LD, 0, 1, 0, 1, 1, LR, LD, 1, 15);
        addL(15); addL(15); addL(15); addA(15);
        // ALU write to x0, then idle
        addVec(0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 15);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15);

        $display("[TB] running %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            wb_exp_t e;
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d alu_ready", i),      32'(alu_ready_m), 32'(vecs[i].exp_ar));
            checkOutput($sformatf("v%0d lsu_ready", i),      32'(lsu_ready_m), 32'(vecs[i].exp_lr));
            checkOutput($sformatf("v%0d alu_ready_sm0", i),  32'(alu_ready_s), 32'(vecs[i].exp_ar0));
            checkOutput($sformatf("v%0d lsu_ready_sm0", i),  32'(lsu_ready_s), 32'(vecs[i].exp_lr0));
            e.idx  = i;
            e.en   = vecs[i].exp_en;
            e.addr = vecs[i].exp_addr;
            e.data = vecs[i].exp_data;
            e.src  = vecs[i].exp_src;
            e.cnt  = vecs[i].exp_cnt;
            sb.push_back(e);
            @(negedge clk);
        end

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
